// File: rtl/stopwatch_tick_ctrl.sv
// Timebase and control for one stopwatch digit: button conditioning, IDLE/RUN/PAUSE
// sequencing, tick prescaler, and the load/val_sel/clear/carry strobes for the digit counter.
module stopwatch_tick_ctrl #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned TICK_HZ      = 100,
  parameter int unsigned WRAP_VAL     = 100,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic [6:0] count_in,
  output logic       load,
  output logic       val_sel,
  output logic       clear,
  output logic       carry,
  output logic       running
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam int unsigned DW  = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          init_pend;
  logic [1:0]    sync1, sync2, db, db_d, act;
  logic [DW-1:0] dcnt [2];
  logic          ss_act, cl_act, tick, wrap;

  // Bit 0 = start/stop, bit 1 = clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      for (int unsigned i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= {btn_clear, btn_start_stop};
      sync2 <= sync1;
      db_d  <= db;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
          db[i]   <= ~db[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    act    = db & ~db_d;
    ss_act = act[0];
    cl_act = act[1];
    tick   = (state == RUN) && (presc == PW'(DIV - 1));
    wrap   = (count_in >= 7'(WRAP_VAL));
  end

  // A tick in the same cycle as a pause request still issues its strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      presc     <= '0;
      running   <= 1'b0;
      load      <= 1'b0;
      val_sel   <= 1'b0;
      clear     <= 1'b0;
      carry     <= 1'b0;
      init_pend <= 1'b1;
    end else begin
      load      <= 1'b0;
      val_sel   <= 1'b0;
      clear     <= 1'b0;
      carry     <= 1'b0;
      init_pend <= 1'b0;
      if (init_pend) begin
        load  <= 1'b1;
        clear <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          presc <= '0;
          if (cl_act) begin
            load  <= 1'b1;
            clear <= 1'b1;
          end else if (ss_act) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
            presc <= '0;
            load  <= 1'b1;
            if (wrap) begin
              val_sel <= 1'b1;
              carry   <= 1'b1;
            end
          end else begin
            presc <= presc + PW'(1);
          end
          if (ss_act) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        PAUSE: begin
          if (cl_act) begin
            state <= IDLE;
            presc <= '0;
            load  <= 1'b1;
            clear <= 1'b1;
          end else if (ss_act) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          presc   <= '0;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_tick_ctrl.sv
// Bench for stopwatch_tick_ctrl with DIV=10, WRAP_VAL=5, DEBOUNCE_CYC=3 and a model digit counter.
module tb_stopwatch_tick_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_cl = 1'b0;
  logic [6:0] count_in;
  logic [6:0] cnt_model = 7'd85;
  logic [6:0] force_val = 7'd0;
  logic       force_en = 1'b0;
  logic       load, val_sel, clear, carry, running;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {int cyc; logic vs; logic cl; logic cy;} exp_t;
  typedef struct {int off; logic vs; logic cl; logic cy; int cnt;} vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t tbl[6];

  stopwatch_tick_ctrl #(
    .CLK_HZ(1000),
    .TICK_HZ(100),
    .WRAP_VAL(5),
    .DEBOUNCE_CYC(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_start_stop(btn_ss),
    .btn_clear(btn_cl),
    .count_in(count_in),
    .load(load),
    .val_sel(val_sel),
    .clear(clear),
    .carry(carry),
    .running(running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Downstream digit counter: clear has priority over val_sel.
  always @(posedge clk)
    if (load) cnt_model <= clear ? 7'd0 : (val_sel ? 7'd1 : cnt_model + 7'd1);

  assign count_in = force_en ? force_val : cnt_model;

  function automatic exp_t mk(input int c, input logic vs, input logic cl, input logic cy);
    exp_t r;
    r.cyc = c; r.vs = vs; r.cl = cl; r.cy = cy;
    return r;
  endfunction

  always @(negedge clk) begin
    n_tests++;
    if (load) begin
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_unexpected: got load at cyc=%0d vs/cl/cy=%b%b%b, expected no load",
                 cyc, val_sel, clear, carry);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || {val_sel, clear, carry} != {e.vs, e.cl, e.cy}) begin
          n_fail++;
          $display("FAIL strobe_match: got cyc=%0d vs/cl/cy=%b%b%b, expected cyc=%0d vs/cl/cy=%b%b%b",
                   cyc, val_sel, clear, carry, e.cyc, e.vs, e.cl, e.cy);
        end
      end
    end else if (val_sel || clear || carry) begin
      n_fail++;
      $display("FAIL strobe_stray: got vs/cl/cy=%b%b%b without load at cyc=%0d, expected 000",
               val_sel, clear, carry, cyc);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic press(input int which, input int n);
    if (which == 0) btn_ss = 1'b1;
    else btn_cl = 1'b1;
    repeat (n) @(negedge clk);
    btn_ss = 1'b0;
    btn_cl = 1'b0;
  endtask

  int c, t, p, q, s, r;

  initial begin
    tbl[0] = '{16, 1'b0, 1'b0, 1'b0, 1};
    tbl[1] = '{26, 1'b0, 1'b0, 1'b0, 2};
    tbl[2] = '{36, 1'b0, 1'b0, 1'b0, 3};
    tbl[3] = '{46, 1'b0, 1'b0, 1'b0, 4};
    tbl[4] = '{56, 1'b0, 1'b0, 1'b0, 5};
    tbl[5] = '{66, 1'b1, 1'b0, 1'b1, 1};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", int'({load, val_sel, clear, carry, running}), 0);

    // Release: a single load+clear in the first cycle.
    c = cyc;
    sb.push_back(mk(c + 1, 1'b0, 1'b1, 1'b0));
    rst_n = 1'b1;
    wait_until(c + 3);
    chk("post_reset_count", int'(cnt_model), 0);
    chk("post_reset_running", int'(running), 0);

    // Glitch shorter than the debounce window.
    c = cyc;
    press(0, 2);
    wait_until(c + 20);
    chk("glitch_running", int'(running), 0);
    chk("glitch_count", int'(cnt_model), 0);

    // Start and count through one full wrap.
    c = cyc;
    for (int i = 0; i < 6; i++) sb.push_back(mk(c + tbl[i].off, tbl[i].vs, tbl[i].cl, tbl[i].cy));
    press(0, 4);
    wait_until(c + 5);
    chk("start_latency_pre", int'(running), 0);
    wait_until(c + 6);
    chk("start_latency", int'(running), 1);
    for (int i = 0; i < 6; i++) begin
      wait_until(c + tbl[i].off + 1);
      chk($sformatf("count_step%0d", i), int'(cnt_model), tbl[i].cnt);
    end

    // Pause with the prescaler at 6, sit 50 clocks, resume: 3 clocks to the next load.
    t = c + 66;
    press(0, 4);
    wait_until(t + 6);
    chk("pause_pre", int'(running), 1);
    wait_until(t + 7);
    chk("pause_running", int'(running), 0);
    wait_until(t + 57);
    p = cyc;
    sb.push_back(mk(p + 9, 1'b0, 1'b0, 1'b0));
    press(0, 4);
    wait_until(p + 5);
    chk("resume_pre", int'(running), 0);
    wait_until(p + 6);
    chk("resume_running", int'(running), 1);
    wait_until(p + 10);
    chk("resume_count", int'(cnt_model), 2);

    // Clear while running is ignored; clear while paused returns to IDLE.
    sb.push_back(mk(p + 19, 1'b0, 1'b0, 1'b0));
    press(1, 4);
    wait_until(p + 20);
    chk("clear_in_run_running", int'(running), 1);
    chk("clear_in_run_count", int'(cnt_model), 3);
    press(0, 4);
    wait_until(p + 26);
    chk("pause2_running", int'(running), 0);
    wait_until(p + 30);
    q = cyc;
    sb.push_back(mk(q + 6, 1'b0, 1'b1, 1'b0));
    press(1, 4);
    wait_until(q + 7);
    chk("pause_clear_count", int'(cnt_model), 0);
    chk("pause_clear_running", int'(running), 0);

    // Restart from IDLE: a full 10 clocks to the first load.
    wait_until(q + 10);
    s = cyc;
    sb.push_back(mk(s + 16, 1'b0, 1'b0, 1'b0));
    press(0, 4);
    wait_until(s + 6);
    chk("restart_running", int'(running), 1);
    wait_until(s + 17);
    chk("restart_count", int'(cnt_model), 1);

    // Out-of-range feedback is treated as a wrap.
    force_val = 7'd120;
    force_en  = 1'b1;
    sb.push_back(mk(s + 26, 1'b1, 1'b0, 1'b1));
    wait_until(s + 27);
    force_en = 1'b0;
    chk("oor_wrap_count", int'(cnt_model), 1);
    sb.push_back(mk(s + 36, 1'b0, 1'b0, 1'b0));
    wait_until(s + 40);
    chk("after_oor_count", int'(cnt_model), 2);

    // Asynchronous reset mid-count, then re-zeroing after release.
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", int'({load, val_sel, clear, carry, running}), 0);
    wait_until(s + 43);
    r = cyc;
    sb.push_back(mk(r + 1, 1'b0, 1'b1, 1'b0));
    rst_n = 1'b1;
    wait_until(r + 3);
    chk("rerst_count", int'(cnt_model), 0);
    chk("rerst_running", int'(running), 0);
    wait_until(r + 20);
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
